// File: rtl/dcache_ctrl_if.sv
// Memory-side bus of the L1 data cache: line request/acknowledge handshake
// with 128-bit write-back and refill data paths.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [127:0]      mem_data_o;
    logic              mem_ack_i;
    logic [127:0]      mem_data_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
        input  mem_ack_i, mem_data_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o,
        output mem_ack_i, mem_data_i
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller with
// same-cycle hits and a stalling write-back/refill FSM on misses.
module dcache_ctrl #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stall_o,
    dcache_ctrl_if.master     mem
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - 4 - IDX_W;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t             state, state_nxt;
    logic [LINES-1:0]   valid, dirty;
    logic [TAG_W-1:0]   tag_arr  [LINES];
    logic [127:0]       line_arr [LINES];

    logic [1:0]         word_sel;
    logic [IDX_W-1:0]   idx, miss_idx;
    logic [TAG_W-1:0]   tag, miss_tag;
    logic               hit, miss, victim_dirty;
    logic               unused_ok;

    assign word_sel     = addr_i[3:2];
    assign idx          = addr_i[4 +: IDX_W];
    assign tag          = addr_i[ADDR_W-1:4+IDX_W];
    assign hit          = req_i & valid[idx] & (tag_arr[idx] == tag);
    assign miss         = req_i & ~hit;
    assign victim_dirty = valid[idx] & dirty[idx];
    assign unused_ok    = &{1'b0, addr_i[1:0]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (miss) state_nxt = victim_dirty ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (mem.mem_ack_i) state_nxt = ALLOCATE;
            ALLOCATE:  if (mem.mem_ack_i) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_o  = 32'h0;
        stall_o = (state != IDLE) | miss;
        if (state == IDLE && hit)
            data_o = line_arr[idx][{word_sel, 5'b00000} +: 32];
    end

    // Status bits and the registered memory port; the port fields are loaded
    // once per phase so they stay stable for the whole request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid          <= '0;
            dirty          <= '0;
            mem.mem_req_o  <= 1'b0;
            mem.mem_we_o   <= 1'b0;
            mem.mem_addr_o <= '0;
            mem.mem_data_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hit && we_i) begin
                        dirty[idx] <= 1'b1;
                    end else if (miss) begin
                        mem.mem_req_o <= 1'b1;
                        if (victim_dirty) begin
                            mem.mem_we_o   <= 1'b1;
                            mem.mem_addr_o <= {tag_arr[idx], idx, 4'b0000};
                            mem.mem_data_o <= line_arr[idx];
                        end else begin
                            mem.mem_we_o   <= 1'b0;
                            mem.mem_addr_o <= {tag, idx, 4'b0000};
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem.mem_ack_i) begin
                        dirty[miss_idx] <= 1'b0;
                        mem.mem_we_o    <= 1'b0;
                        mem.mem_addr_o  <= {miss_tag, miss_idx, 4'b0000};
                    end
                end
                ALLOCATE: begin
                    if (mem.mem_ack_i) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        mem.mem_req_o   <= 1'b0;
                        mem.mem_we_o    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays and the latched miss address carry no reset; valid
    // bits gate every use of them.
    always_ff @(posedge clk_i) begin
        if (state == IDLE && miss) begin
            miss_idx <= idx;
            miss_tag <= tag;
        end
        if (state == IDLE && hit && we_i)
            line_arr[idx][{word_sel, 5'b00000} +: 32] <= data_i;
        if (state == ALLOCATE && mem.mem_ack_i) begin
            line_arr[miss_idx] <= mem.mem_data_i;
            tag_arr[miss_idx]  <= miss_tag;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hand-computed miss/hit/write-back scenarios.
module tb_dcache_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;
    int stalls;

    localparam logic [127:0] LINE1 = {32'hD0D0_0004, 32'hC0C0_0003, 32'hB0B0_0002, 32'hA0A0_0001};
    localparam logic [127:0] LINE2 = {32'h4444_0008, 32'h3333_0007, 32'h2222_0006, 32'h1111_0005};
    localparam logic [127:0] LINE3 = {32'h9999_000C, 32'h8888_000B, 32'h7777_000A, 32'h6666_0009};
    localparam logic [127:0] LINE4 = {32'hF00D_0010, 32'hF00D_000F, 32'hF00D_000E, 32'hF00D_000D};

    dcache_ctrl_if #(.ADDR_W(32)) mif ();

    dcache_ctrl #(.LINES(16), .ADDR_W(32)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .stall_o (stall_o),
        .mem     (mif.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic test_reset();
        rst_i = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
        mif.mem_ack_i = 1'b0; mif.mem_data_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall_o); end
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", data_o); end
        checks++; if (mif.mem_req_o !== 1'b0 || mif.mem_we_o !== 1'b0) begin errors++; $display("FAIL rst_memctl got req=%0b we=%0b exp 0 0", mif.mem_req_o, mif.mem_we_o); end
        checks++; if (mif.mem_addr_o !== 32'h0 || mif.mem_data_o !== 128'h0) begin errors++; $display("FAIL rst_membus got addr=%h data=%h exp 0", mif.mem_addr_o, mif.mem_data_o); end
        @(negedge clk_i); rst_i = 1'b1;
    endtask

    task automatic test_clean_miss();
        stalls = 0;
        @(negedge clk_i); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40; #1;
        if (stall_o) stalls++;
        checks++; if (mif.mem_req_o !== 1'b0) begin errors++; $display("FAIL miss_c0_req got %0b exp 0", mif.mem_req_o); end
        @(negedge clk_i); #1;
        if (stall_o) stalls++;
        checks++; if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b0 || mif.mem_addr_o !== 32'h40) begin errors++; $display("FAIL miss_alloc got req=%0b we=%0b addr=%h exp 1 0 40", mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o); end
        @(negedge clk_i); #1;
        if (stall_o) stalls++;
        @(negedge clk_i); mif.mem_ack_i = 1'b1; mif.mem_data_i = LINE1; #1;
        if (stall_o) stalls++;
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
        checks++; if (stalls != 4) begin errors++; $display("FAIL miss_stall_len got %0d exp 4", stalls); end
        checks++; if (stall_o !== 1'b0 || data_o !== 32'hA0A0_0001) begin errors++; $display("FAIL miss_fill_hit got stall=%0b data=%h exp 0 a0a00001", stall_o, data_o); end
        checks++; if (mif.mem_req_o !== 1'b0) begin errors++; $display("FAIL miss_req_drop got %0b exp 0", mif.mem_req_o); end
    endtask

    task automatic test_load_hit();
        @(negedge clk_i); addr_i = 32'h44; #1;
        checks++; if (stall_o !== 1'b0 || data_o !== 32'hB0B0_0002) begin errors++; $display("FAIL hit_44 got stall=%0b data=%h exp 0 b0b00002", stall_o, data_o); end
        checks++; if (mif.mem_req_o !== 1'b0) begin errors++; $display("FAIL hit_44_req got %0b exp 0", mif.mem_req_o); end
    endtask

    task automatic test_dirty_evict();
        stalls = 0;
        @(negedge clk_i); we_i = 1'b1; addr_i = 32'h48; data_i = 32'hDEAD_BEEF; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL store_hit_stall got %0b exp 0", stall_o); end
        @(negedge clk_i); we_i = 1'b0; addr_i = 32'h140; #1;
        if (stall_o) stalls++;
        @(negedge clk_i); mif.mem_ack_i = 1'b1; #1;
        if (stall_o) stalls++;
        checks++; if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b1 || mif.mem_addr_o !== 32'h40) begin errors++; $display("FAIL wb_ctl got req=%0b we=%0b addr=%h exp 1 1 40", mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o); end
        checks++; if (mif.mem_data_o !== {32'hD0D0_0004, 32'hDEAD_BEEF, 32'hB0B0_0002, 32'hA0A0_0001}) begin errors++; $display("FAIL wb_data got %h exp d0d00004deadbeefb0b00002a0a00001", mif.mem_data_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
        if (stall_o) stalls++;
        checks++; if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b0 || mif.mem_addr_o !== 32'h140) begin errors++; $display("FAIL wb_then_alloc got req=%0b we=%0b addr=%h exp 1 0 140", mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b1; mif.mem_data_i = LINE2; #1;
        if (stall_o) stalls++;
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
        checks++; if (stalls != 4) begin errors++; $display("FAIL dirty_stall_len got %0d exp 4", stalls); end
        checks++; if (stall_o !== 1'b0 || data_o !== 32'h1111_0005) begin errors++; $display("FAIL dirty_fill_hit got stall=%0b data=%h exp 0 11110005", stall_o, data_o); end
    endtask

    task automatic test_store_miss();
        @(negedge clk_i); we_i = 1'b1; addr_i = 32'h80; data_i = 32'hCAFE_F00D; #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL smiss_stall got %0b exp 1", stall_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b1; mif.mem_data_i = LINE3; #1;
        checks++; if (mif.mem_req_o !== 1'b1 || mif.mem_we_o !== 1'b0 || mif.mem_addr_o !== 32'h80) begin errors++; $display("FAIL smiss_alloc got req=%0b we=%0b addr=%h exp 1 0 80", mif.mem_req_o, mif.mem_we_o, mif.mem_addr_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL smiss_merge_stall got %0b exp 0", stall_o); end
        @(negedge clk_i); we_i = 1'b0; #1;
        checks++; if (data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL smiss_reload got %h exp cafef00d", data_o); end
        @(negedge clk_i); addr_i = 32'h180; #1;
        @(negedge clk_i); mif.mem_ack_i = 1'b1; mif.mem_data_i = LINE4; #1;
        checks++; if (mif.mem_we_o !== 1'b1 || mif.mem_addr_o !== 32'h80) begin errors++; $display("FAIL smiss_evict_ctl got we=%0b addr=%h exp 1 80", mif.mem_we_o, mif.mem_addr_o); end
        checks++; if (mif.mem_data_o !== {32'h9999_000C, 32'h8888_000B, 32'h7777_000A, 32'hCAFE_F00D}) begin errors++; $display("FAIL smiss_evict_data got %h exp 9999000c8888000b7777000acafef00d", mif.mem_data_o); end
        @(negedge clk_i); #1;
        checks++; if (mif.mem_addr_o !== 32'h180 || mif.mem_we_o !== 1'b0) begin errors++; $display("FAIL smiss_evict_alloc got we=%0b addr=%h exp 0 180", mif.mem_we_o, mif.mem_addr_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
        checks++; if (stall_o !== 1'b0 || data_o !== 32'hF00D_000D) begin errors++; $display("FAIL smiss_evict_hit got stall=%0b data=%h exp 0 f00d000d", stall_o, data_o); end
    endtask

    task automatic test_idle_ack();
        @(negedge clk_i); req_i = 1'b0; mif.mem_ack_i = 1'b1; mif.mem_data_i = '1; #1;
        checks++; if (data_o !== 32'h0 || stall_o !== 1'b0) begin errors++; $display("FAIL noreq got data=%h stall=%0b exp 0 0", data_o, stall_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b0; req_i = 1'b1; addr_i = 32'h14C; #1;
        checks++; if (mif.mem_req_o !== 1'b0 || stall_o !== 1'b0 || data_o !== 32'h4444_0008) begin errors++; $display("FAIL idle_ack got req=%0b stall=%0b data=%h exp 0 0 44440008", mif.mem_req_o, stall_o, data_o); end
    endtask

    task automatic test_reset_mid_alloc();
        @(negedge clk_i); addr_i = 32'h200; #1;
        @(negedge clk_i); #1;
        checks++; if (mif.mem_req_o !== 1'b1) begin errors++; $display("FAIL rma_req_up got %0b exp 1", mif.mem_req_o); end
        rst_i = 1'b0; #1;
        checks++; if (mif.mem_req_o !== 1'b0) begin errors++; $display("FAIL rma_req_drop got %0b exp 0", mif.mem_req_o); end
        @(negedge clk_i); rst_i = 1'b1; addr_i = 32'h140; #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rma_invalidated got stall=%0b exp 1", stall_o); end
        addr_i = 32'h200; #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rma_remiss got stall=%0b exp 1", stall_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b1; mif.mem_data_i = LINE4; #1;
        checks++; if (mif.mem_addr_o !== 32'h200 || mif.mem_we_o !== 1'b0) begin errors++; $display("FAIL rma_refill got we=%0b addr=%h exp 0 200", mif.mem_we_o, mif.mem_addr_o); end
        @(negedge clk_i); mif.mem_ack_i = 1'b0; #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words [4];
        exp_words[0] = 32'hF00D_000D; exp_words[1] = 32'hF00D_000E;
        exp_words[2] = 32'hF00D_000F; exp_words[3] = 32'hF00D_0010;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk_i);
            addr_i = 32'h200 + 32'(4 * i); #1;
            checks++; if (stall_o !== 1'b0 || data_o !== exp_words[i]) begin errors++; $display("FAIL b2b_%0d got stall=%0b data=%h exp 0 %h", i, stall_o, data_o, exp_words[i]); end
        end
        @(negedge clk_i); req_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_load_hit();
        test_dirty_evict();
        test_store_miss();
        test_idle_ack();
        test_reset_mid_alloc();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
